// File: rtl/regfile_reader_pkg.sv
// Shared decode helpers and FSM state type for the operand-fetch stage.
// Instruction words are ARM-style 32-bit encodings.
package regfile_reader_pkg;

    localparam int          INST_W       = 32;
    localparam int          REG_ADDR_W   = 4;
    localparam logic [3:0]  REG_PC_INDEX = 4'd15;
    localparam logic [3:0]  OPC_MOV      = 4'b1101;
    localparam logic [3:0]  OPC_MVN      = 4'b1111;

    typedef enum logic [1:0] {
        FMT_DATA   = 2'd0,
        FMT_MEM    = 2'd1,
        FMT_BRANCH = 2'd2,
        FMT_OTHER  = 2'd3
    } inst_fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_STALL = 2'd2
    } reader_state_t;

    function automatic inst_fmt_t decode_format(input logic [INST_W-1:0] inst);
        inst_fmt_t fmt;
        casez (inst[27:25])
            3'b00?:  fmt = FMT_DATA;
            3'b01?:  fmt = FMT_MEM;
            3'b101:  fmt = FMT_BRANCH;
            default: fmt = FMT_OTHER;
        endcase
        return fmt;
    endfunction

    function automatic logic [REG_ADDR_W-1:0] decode_Rn(input logic [INST_W-1:0] inst);
        return inst[19:16];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] decode_Rm(input logic [INST_W-1:0] inst);
        return inst[3:0];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] decode_Rd(input logic [INST_W-1:0] inst);
        return inst[15:12];
    endfunction

    // MOV/MVN carry a don't-care Rn field.
    function automatic logic decode_uses_Rn(input logic [INST_W-1:0] inst);
        logic used;
        case (decode_format(inst))
            FMT_DATA: used = !(inst[24:21] == OPC_MOV || inst[24:21] == OPC_MVN);
            FMT_MEM:  used = 1'b1;
            default:  used = 1'b0;
        endcase
        return used;
    endfunction

    // Data-processing uses Rm for register operand 2; memory uses it for register offsets.
    function automatic logic decode_uses_Rm(input logic [INST_W-1:0] inst);
        logic used;
        case (decode_format(inst))
            FMT_DATA: used = !inst[25];
            FMT_MEM:  used = inst[25];
            default:  used = 1'b0;
        endcase
        return used;
    endfunction

    function automatic logic decode_uses_Rd(input logic [INST_W-1:0] inst);
        return (decode_format(inst) == FMT_MEM) && !inst[20];
    endfunction

endpackage

// File: rtl/regfile_reader_hazard.sv
// Per-port r15/writeback match detection and read-after-write hazard for the reader.
// REGFILE_READER_BYPASS_EN turns writeback matches into forwards instead of stalls.
module regfile_reader_hazard
    import regfile_reader_pkg::*;
#(
    parameter int REG_COUNT_L2 = 4
) (
    input  logic [2:0]                   uses,
    input  logic [2:0][REG_COUNT_L2-1:0] addr,
    input  logic                         ex_write_pending,
    input  logic [REG_COUNT_L2-1:0]      ex_write_addr,
    input  logic                         wb_write_enable,
    input  logic [REG_COUNT_L2-1:0]      wb_write_addr,
    output logic                         hazard,
    output logic [2:0]                   pc_sel,
    output logic [2:0]                   wb_sel
);

    localparam logic [REG_COUNT_L2-1:0] PC_ADDR = REG_COUNT_L2'(REG_PC_INDEX);

    logic [2:0] ex_hit;
    logic [2:0] wb_hazard;

    for (genvar i = 0; i < 3; i++) begin : g_port
        logic is_pc;
        logic wb_hit;
        assign is_pc     = (addr[i] == PC_ADDR);
        assign pc_sel[i] = is_pc;
        // r15 is never written by the executor in a way this stage waits on.
        assign ex_hit[i] = uses[i] && !is_pc && ex_write_pending && (addr[i] == ex_write_addr);
        assign wb_hit    = !is_pc && wb_write_enable && (addr[i] == wb_write_addr);
`ifdef REGFILE_READER_BYPASS_EN
        assign wb_sel[i]    = wb_hit;
        assign wb_hazard[i] = 1'b0;
`else
        assign wb_sel[i]    = 1'b0;
        assign wb_hazard[i] = uses[i] && wb_hit;
`endif
    end

    assign hazard = (|ex_hit) || (|wb_hazard);

endmodule

// File: rtl/regfile_reader.sv
// Operand-fetch stage: reads Rn/Rm/Rd, substitutes PC+8 for r15, stalls on RAW hazards.
// Define REGFILE_READER_BYPASS_EN to forward writeback data instead of stalling on it.
module regfile_reader
    import regfile_reader_pkg::*;
#(
    parameter int BIT_WIDTH    = 32,
    parameter int REG_COUNT_L2 = 4
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    enable,
    output logic                    ready,
    output logic                    stall,
    input  logic [BIT_WIDTH-1:0]    pc,
    input  logic [BIT_WIDTH-1:0]    decoder_inst,
    output logic [REG_COUNT_L2-1:0] regfile_read_addr1,
    output logic [REG_COUNT_L2-1:0] regfile_read_addr2,
    output logic [REG_COUNT_L2-1:0] regfile_read_addr3,
    input  logic [BIT_WIDTH-1:0]    regfile_read_value1,
    input  logic [BIT_WIDTH-1:0]    regfile_read_value2,
    input  logic [BIT_WIDTH-1:0]    regfile_read_value3,
    input  logic                    ex_write_pending,
    input  logic [REG_COUNT_L2-1:0] ex_write_addr,
    input  logic                    wb_write_enable,
    input  logic [REG_COUNT_L2-1:0] wb_write_addr,
    input  logic [BIT_WIDTH-1:0]    wb_write_value,
    output logic [BIT_WIDTH-1:0]    reader_inst,
    output logic [BIT_WIDTH-1:0]    Rn_value,
    output logic [BIT_WIDTH-1:0]    Rm_value,
    output logic [BIT_WIDTH-1:0]    Rd_value
);

    logic [INST_W-1:0]                inst;
    logic [2:0]                       uses;
    logic [2:0][REG_COUNT_L2-1:0]     addr;
    logic [2:0][BIT_WIDTH-1:0]        read_value;
    logic [2:0][BIT_WIDTH-1:0]        operand;
    logic [BIT_WIDTH-1:0]             pc_plus8;
    logic                             hazard;
    logic [2:0]                       pc_sel;
    logic [2:0]                       wb_sel;
    reader_state_t                    state, state_next;
    logic                             latch;

    assign inst = INST_W'(decoder_inst);

    assign uses    = {decode_uses_Rd(inst), decode_uses_Rm(inst), decode_uses_Rn(inst)};
    assign addr[0] = REG_COUNT_L2'(decode_Rn(inst));
    assign addr[1] = REG_COUNT_L2'(decode_Rm(inst));
    assign addr[2] = REG_COUNT_L2'(decode_Rd(inst));

    assign regfile_read_addr1 = addr[0];
    assign regfile_read_addr2 = addr[1];
    assign regfile_read_addr3 = addr[2];

    assign read_value[0] = regfile_read_value1;
    assign read_value[1] = regfile_read_value2;
    assign read_value[2] = regfile_read_value3;

    // Wraps naturally at BIT_WIDTH.
    assign pc_plus8 = pc + BIT_WIDTH'(8);

    regfile_reader_hazard #(.REG_COUNT_L2(REG_COUNT_L2)) u_hazard (
        .uses             (uses),
        .addr             (addr),
        .ex_write_pending (ex_write_pending),
        .ex_write_addr    (ex_write_addr),
        .wb_write_enable  (wb_write_enable),
        .wb_write_addr    (wb_write_addr),
        .hazard           (hazard),
        .pc_sel           (pc_sel),
        .wb_sel           (wb_sel)
    );

    for (genvar i = 0; i < 3; i++) begin : g_operand
`ifdef REGFILE_READER_BYPASS_EN
        assign operand[i] = !uses[i]  ? '0 :
                            pc_sel[i] ? pc_plus8 :
                            wb_sel[i] ? wb_write_value :
                                        read_value[i];
`else
        assign operand[i] = !uses[i]  ? '0 :
                            pc_sel[i] ? pc_plus8 :
                                        read_value[i];
`endif
    end

`ifndef REGFILE_READER_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{wb_write_value, wb_sel};
`endif

    always_ff @(posedge clk) begin
        if (nreset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // The decoder holds its instruction through STALL, so a stall exit re-reads operands.
    always_comb begin
        state_next = state;
        latch      = 1'b0;
        case (state)
            ST_STALL: begin
                if (!hazard) begin
                    state_next = ST_VALID;
                    latch      = 1'b1;
                end
            end
            default: begin
                if (enable && !hazard) begin
                    state_next = ST_VALID;
                    latch      = 1'b1;
                end else if (enable) begin
                    state_next = ST_STALL;
                end else begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            reader_inst <= '0;
            Rn_value    <= '0;
            Rm_value    <= '0;
            Rd_value    <= '0;
        end else if (latch) begin
            reader_inst <= decoder_inst;
            Rn_value    <= operand[0];
            Rm_value    <= operand[1];
            Rd_value    <= operand[2];
        end
    end

    assign ready = (state == ST_VALID);
    assign stall = hazard && (enable || state == ST_STALL);

endmodule

// File: tb/tb_regfile_reader.sv
// Scoreboard bench for regfile_reader: stimulus pushes expected operands, a negedge monitor pops them.
// Expected stall counts follow REGFILE_READER_BYPASS_EN when the same macro is passed to the bench.
module tb_regfile_reader;

    localparam int BW = 32;
    localparam int AW = 4;

    localparam logic [31:0] I_ADD  = 32'hE0821003; // ADD r1,r2,r3
    localparam logic [31:0] I_ADDP = 32'hE28F0004; // ADD r0,r15,#4
    localparam logic [31:0] I_STR  = 32'hE5854000; // STR r4,[r5]
    localparam logic [31:0] I_B    = 32'hEA000000; // B
    localparam logic [31:0] I_SUB  = 32'hE0454006; // SUB r4,r5,r6
    localparam logic [31:0] I_MOV  = 32'hE1A07008; // MOV r7,r8
    localparam logic [31:0] I_ORR  = 32'hE38A9001; // ORR r9,r10,#1

`ifdef REGFILE_READER_BYPASS_EN
    localparam int WB_STALLS = 0;
`else
    localparam int WB_STALLS = 1;
`endif

    logic          clk = 1'b0;
    logic          nreset = 1'b1;
    logic          enable = 1'b0;
    logic          ready, stall;
    logic [BW-1:0] pc = '0;
    logic [BW-1:0] decoder_inst = '0;
    logic [AW-1:0] regfile_read_addr1, regfile_read_addr2, regfile_read_addr3;
    logic [BW-1:0] regfile_read_value1, regfile_read_value2, regfile_read_value3;
    logic          ex_write_pending = 1'b0;
    logic [AW-1:0] ex_write_addr = '0;
    logic          wb_write_enable = 1'b0;
    logic [AW-1:0] wb_write_addr = '0;
    logic [BW-1:0] wb_write_value = '0;
    logic [BW-1:0] reader_inst, Rn_value, Rm_value, Rd_value;

    logic [BW-1:0] regs [16];

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [31:0] rd;
    } exp_t;

    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_ready = 1'b0;

    always #5 clk = ~clk;

    regfile_reader #(.BIT_WIDTH(BW), .REG_COUNT_L2(AW)) dut (
        .clk                 (clk),
        .nreset              (nreset),
        .enable              (enable),
        .ready               (ready),
        .stall               (stall),
        .pc                  (pc),
        .decoder_inst        (decoder_inst),
        .regfile_read_addr1  (regfile_read_addr1),
        .regfile_read_addr2  (regfile_read_addr2),
        .regfile_read_addr3  (regfile_read_addr3),
        .regfile_read_value1 (regfile_read_value1),
        .regfile_read_value2 (regfile_read_value2),
        .regfile_read_value3 (regfile_read_value3),
        .ex_write_pending    (ex_write_pending),
        .ex_write_addr       (ex_write_addr),
        .wb_write_enable     (wb_write_enable),
        .wb_write_addr       (wb_write_addr),
        .wb_write_value      (wb_write_value),
        .reader_inst         (reader_inst),
        .Rn_value            (Rn_value),
        .Rm_value            (Rm_value),
        .Rd_value            (Rd_value)
    );

    function automatic logic [31:0] init_val(input int i);
        case (i)
            2:       return 32'd5;
            3:       return 32'd7;
            4:       return 32'd1;
            default: return 32'h1000 + 32'(i);
        endcase
    endfunction

    // Small regfile model: loaded during reset, written by the writeback port.
    always @(posedge clk) begin
        if (nreset) begin
            for (int i = 0; i < 16; i++) regs[i] <= init_val(i);
        end else if (wb_write_enable) begin
            regs[wb_write_addr] <= wb_write_value;
        end
    end

    assign regfile_read_value1 = regs[regfile_read_addr1];
    assign regfile_read_value2 = regs[regfile_read_addr2];
    assign regfile_read_value3 = regs[regfile_read_addr3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!nreset && ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready: got ready=1 inst=%h, expected no output", reader_inst);
            end else begin
                e = sb.pop_front();
                check("reader_inst", reader_inst, e.inst);
                check("Rn_value", Rn_value, e.rn);
                check("Rm_value", Rm_value, e.rm);
                check("Rd_value", Rd_value, e.rd);
            end
        end
    end

    // Present inst until accepted; executor/writeback events are one-shot and retire after each edge.
    task automatic send(input logic [31:0] inst, input logic [31:0] rn, input logic [31:0] rm,
                        input logic [31:0] rd, input int exp_stalls, input string tag);
        int stalls = 0;
        bit done = 0;
        exp_t e;
        decoder_inst = inst;
        enable = 1'b1;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            @(negedge clk);
            if (chk_ready && cyc == 0) check({tag, "_ready_prev"}, 32'(ready), 32'd1);
            if (stalls > 0) check({tag, "_ready_in_stall"}, 32'(ready), 32'd0);
            if (!stall) begin
                e = '{inst: inst, rn: rn, rm: rm, rd: rd};
                sb.push_back(e);
                done = 1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
            ex_write_pending = 1'b0;
            wb_write_enable  = 1'b0;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got stall held 20 cycles, expected acceptance", tag);
        end
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    endtask

    task automatic idle();
        enable = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a live instruction presented.
        nreset = 1'b1;
        enable = 1'b1;
        decoder_inst = I_ADD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_reader_inst", reader_inst, 32'd0);
        check("rst_Rn", Rn_value, 32'd0);
        check("rst_Rm", Rm_value, 32'd0);
        check("rst_Rd", Rd_value, 32'd0);
        @(posedge clk);
        #1;
        nreset = 1'b0;
        enable = 1'b0;

        send(I_ADD, 32'd5, 32'd7, 32'd0, 0, "add");
        idle();

        pc = 32'h100;
        send(I_ADDP, 32'h108, 32'd0, 32'd0, 0, "pc");
        pc = 32'hFFFF_FFFC;
        send(I_ADDP, 32'h4, 32'd0, 32'd0, 0, "pc_wrap");
        idle();

        ex_write_pending = 1'b1;
        ex_write_addr = 4'd2;
        send(I_ADD, 32'd5, 32'd7, 32'd0, 1, "ex_haz");
        idle();

        wb_write_enable = 1'b1;
        wb_write_addr = 4'd4;
        wb_write_value = 32'h55;
        send(I_STR, 32'h1005, 32'd0, 32'h55, WB_STALLS, "wb");
        idle();

        ex_write_pending = 1'b1;
        ex_write_addr = 4'd0;
        send(I_B, 32'd0, 32'd0, 32'd0, 0, "branch");
        idle();

        regs_restore: begin
            wb_write_enable = 1'b1;
            wb_write_addr = 4'd4;
            wb_write_value = 32'd1;
            idle();
        end

        send(I_ADD, 32'd5, 32'd7, 32'd0, 0, "b2b0");
        chk_ready = 1'b1;
        send(I_SUB, 32'h1005, 32'h1006, 32'd0, 0, "b2b1");
        send(I_MOV, 32'd0, 32'h1008, 32'd0, 0, "b2b2");
        send(I_ORR, 32'h100A, 32'd0, 32'd0, 0, "b2b3");
        chk_ready = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check("b2b_last_ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("drop_enable_ready", 32'(ready), 32'd0);

        // Reset while stalled drops the held instruction.
        @(posedge clk);
        #1;
        ex_write_pending = 1'b1;
        ex_write_addr = 4'd3;
        decoder_inst = I_ADD;
        enable = 1'b1;
        @(negedge clk);
        check("mid_stall_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        ex_write_pending = 1'b0;
        enable = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b0;
        @(negedge clk);
        check("mid_stall_rst_ready", 32'(ready), 32'd0);
        check("mid_stall_rst_stall", 32'(stall), 32'd0);
        check("mid_stall_rst_Rn", Rn_value, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
